// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver (and the planned
// transmitter rework).
//   UART_DATA_BITS    - payload bits per frame (8N1)
//   UART_IDLE_LEVEL   - line level when nothing is being sent
//   uart_state_e      - frame FSM states
//   calc_clks_per_bit - clock cycles per bit for a given clock and baud rate
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte stream from the UART receiver to its consumer.
//   rx_data   - received byte
//   rx_valid  - rx_data holds an unconsumed byte
//   rx_ready  - consumer takes rx_data when rx_valid && rx_ready
//   frame_err - one-cycle pulse, stop bit was low
//   overrun   - one-cycle pulse, byte dropped because the buffer was full
// master: the receiver; slave: the consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops load RESET_VAL
//   d_i   - asynchronous input
//   q_o   - synchronised output, two to three cycles behind d_i
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry output buffer.
//   clk    - system clock
//   ck_rst - asynchronous active-low reset
//   rxd    - serial line, idle high, asynchronous to clk
//   rx_if  - byte stream to the consumer (rx_data/rx_valid/rx_ready,
//            frame_err and overrun pulses)
// Each bit is sampled once at its midpoint, measured from the cycle in
// which the synchronised line was first seen low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic      clk,
    input  logic      ck_rst,
    input  logic      rxd,
    uart_rx_if.master rx_if
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    logic                      rxd_s;
    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          baud_q, baud_d;
    logic [IDX_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      deliver;
    logic                      half_tick;
    logic                      bit_tick;

    // Reset value matches the idle line so no start bit is seen out of reset.
    sync_2ff #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (ck_rst),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    // The counter is held at zero in IDLE, so on entering START it counts
    // cycles since T0 minus one; HALF_LAST therefore lands on T0+HALF_BIT.
    assign half_tick = (baud_q == HALF_LAST);
    assign bit_tick  = (baud_q == BIT_LAST);

    always_ff @(posedge clk or negedge ck_rst) begin
        if (!ck_rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (rxd_s != UART_IDLE_LEVEL) state_d = START;
            START:     if (half_tick) state_d = rxd_s ? IDLE : DATA;
            DATA:      if (bit_tick && (bit_q == IDX_LAST)) state_d = STOP;
            STOP:      if (bit_tick) state_d = rxd_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxd_s == UART_IDLE_LEVEL) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_d      = baud_q + CNT_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        unique case (state_q)
            IDLE: baud_d = '0;
            START: begin
                if (half_tick) begin
                    baud_d = '0;
                    bit_d  = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    baud_d  = '0;
                    shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + IDX_W'(1);
                end
            end
            STOP: begin
                if (bit_tick) begin
                    baud_d = '0;
                    if (rxd_s) deliver     = 1'b1;
                    else       frame_err_d = 1'b1;
                end
            end
            WAIT_IDLE: baud_d = '0;
            default:   baud_d = '0;
        endcase

        // A consume in the delivery cycle frees the slot for the new byte.
        if (deliver) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed stimulus with a byte scoreboard for uart_rx at
// 16 clocks per bit.
module tb_uart_rx;

    logic clk    = 1'b0;
    logic ck_rst = 1'b0;
    logic rxd    = 1'b1;

    uart_rx_if rx_if();

    uart_rx #(
        .CLOCK_FREQ (100_000_000),
        .BAUD_RATE  (6_250_000)
    ) dut (
        .clk    (clk),
        .ck_rst (ck_rst),
        .rxd    (rxd),
        .rx_if  (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks   = 0;
    int         errors   = 0;
    logic [7:0] exp_q[$];
    int         hs_cnt   = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         start_cyc = 0;
    bit         meas_lat = 1'b0;
    logic       prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (ck_rst) begin
            if (rx_if.frame_err) ferr_cnt++;
            if (rx_if.overrun)   ovr_cnt++;
            if (meas_lat && rx_if.rx_valid && !prev_valid) begin
                checks++;
                if ((cyc - start_cyc) < 154 || (cyc - start_cyc) > 156) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles expected 154..156", cyc - start_cyc);
                end
            end
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", rx_if.rx_data);
                end else begin
                    chk("rx_data", int'(rx_if.rx_data), int'(exp_q.pop_front()));
                end
            end
        end
        prev_valid = rx_if.rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame, 16 cycles per bit; leaves the line at stop_bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(16);
        end
        rxd = stop_bit;
        tick(16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int hs0, fe0, ov0;

    initial begin
        rx_if.rx_ready = 1'b0;
        // Reset
        tick(2);
        chk("rst_rx_data", int'(rx_if.rx_data), 0);
        chk("rst_rx_valid", int'(rx_if.rx_valid), 0);
        chk("rst_frame_err", int'(rx_if.frame_err), 0);
        chk("rst_overrun", int'(rx_if.overrun), 0);
        ck_rst = 1'b1;
        tick(1000);
        chk("idle_handshakes", hs_cnt, 0);
        chk("idle_frame_err", ferr_cnt, 0);
        chk("idle_overrun", ovr_cnt, 0);
        chk("idle_rx_valid", int'(rx_if.rx_valid), 0);

        // Two bytes with consumer always ready
        rx_if.rx_ready = 1'b1;
        meas_lat = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1);
        tick(20);
        meas_lat = 1'b0;
        chk("two_bytes_hs", hs_cnt - hs0, 2);
        chk("two_bytes_q", exp_q.size(), 0);
        chk("two_bytes_ferr", ferr_cnt, 0);

        // Short glitch is rejected, following frame still received
        hs0 = hs_cnt;
        fe0 = ferr_cnt;
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(40);
        chk("glitch_hs", hs_cnt - hs0, 0);
        chk("glitch_ferr", ferr_cnt - fe0, 0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        tick(20);
        chk("after_glitch_hs", hs_cnt - hs0, 1);
        chk("after_glitch_q", exp_q.size(), 0);

        // Framing error followed by a break, then a good frame
        hs0 = hs_cnt;
        fe0 = ferr_cnt;
        send_byte(8'hFF, 1'b0);
        tick(40);
        rxd = 1'b1;
        tick(20);
        chk("ferr_pulses", ferr_cnt - fe0, 1);
        chk("ferr_hs", hs_cnt - hs0, 0);
        chk("ferr_rx_valid", int'(rx_if.rx_valid), 0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        tick(20);
        chk("after_ferr_hs", hs_cnt - hs0, 1);
        chk("after_ferr_q", exp_q.size(), 0);
        chk("after_ferr_pulses", ferr_cnt - fe0, 1);

        // Overrun: second byte dropped while the first is unconsumed
        rx_if.rx_ready = 1'b0;
        hs0 = hs_cnt;
        ov0 = ovr_cnt;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        tick(5);
        chk("ovr_pulses", ovr_cnt - ov0, 1);
        chk("ovr_rx_data", int'(rx_if.rx_data), 8'h12);
        chk("ovr_rx_valid", int'(rx_if.rx_valid), 1);
        chk("ovr_hs_before", hs_cnt - hs0, 0);
        rx_if.rx_ready = 1'b1;
        tick(20);
        chk("ovr_hs_after", hs_cnt - hs0, 1);
        chk("ovr_rx_valid_after", int'(rx_if.rx_valid), 0);
        chk("ovr_q", exp_q.size(), 0);

        // Consume in the same cycle as the next delivery
        rx_if.rx_ready = 1'b0;
        hs0 = hs_cnt;
        ov0 = ovr_cnt;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        exp_q.push_back(8'h34);
        fork
            send_byte(8'h34, 1'b1);
            begin
                tick(154);
                rx_if.rx_ready = 1'b1;
                tick(1);
                rx_if.rx_ready = 1'b0;
            end
        join
        tick(5);
        chk("simul_hs", hs_cnt - hs0, 1);
        chk("simul_overrun", ovr_cnt - ov0, 0);
        chk("simul_rx_data", int'(rx_if.rx_data), 8'h34);
        chk("simul_rx_valid", int'(rx_if.rx_valid), 1);
        rx_if.rx_ready = 1'b1;
        tick(20);
        chk("simul_hs_after", hs_cnt - hs0, 2);
        chk("simul_q", exp_q.size(), 0);
        chk("simul_rx_valid_after", int'(rx_if.rx_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
